// File: rtl/fetch_pkg.sv
// fetch_pkg: shared definitions for the instruction fetch stage.
//   - Width constants for PC/program address, instruction word and opcode
//     field.
//   - OP_HLT: the opcode that stops execution.
//   - fetch_state_t: fetch controller state encoding.
package fetch_pkg;

    localparam int NBITS_PC     = 11;
    localparam int NBITS_INSTR  = 16;
    localparam int NBITS_OPCODE = 5;
    localparam int NBITS_CNT    = 32;

    localparam logic [NBITS_OPCODE-1:0] OP_HLT = 5'b00000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        RUN   = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/program_memory.sv
// program_memory: 2^ADDR_W x DATA_W program store intended for block RAM.
//   i_clock    : clock, rising edge
//   i_reset    : asynchronous active-high reset (read register only)
//   i_wr_en    : write strobe
//   i_wr_addr  : write address
//   i_wr_data  : write data
//   i_rd_en    : read enable; the read register holds when low
//   i_rd_addr  : read address
//   o_rd_data  : registered read data (one cycle latency)
// The array itself is never reset, so contents survive a reset of the CPU.
module program_memory #(
    parameter int ADDR_W = fetch_pkg::NBITS_PC,
    parameter int DATA_W = fetch_pkg::NBITS_INSTR
) (
    input  logic              i_clock,
    input  logic              i_reset,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [DATA_W-1:0] o_rd_data
);

    logic [DATA_W-1:0] mem_reg [0:(2**ADDR_W)-1];
    logic [DATA_W-1:0] rd_data_reg;

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem_reg[i_wr_addr] <= i_wr_data;
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            rd_data_reg <= '0;
        end else if (i_rd_en) begin
            rd_data_reg <= mem_reg[i_rd_addr];
        end
    end

    assign o_rd_data = rd_data_reg;

endmodule

// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch stage downstream of the PC register.
//   i_clock       : clock, rising edge
//   i_reset       : asynchronous active-high reset
//   i_start       : level, starts execution from IDLE
//   i_stall       : downstream not ready, hold the current instruction
//   i_load_en     : program memory write strobe (honoured in IDLE/HALT)
//   i_load_addr   : program memory write address
//   i_load_data   : program memory write data
//   i_pc          : current PC from the pc register
//   o_wr_pc       : PC write enable (PC increments when high)
//   o_instruction : fetched instruction
//   o_opcode      : instruction opcode field (MSBs)
//   o_operand     : instruction operand field (LSBs)
//   o_valid       : o_instruction holds a real instruction
//   o_halt        : HLT executed, held until reset
//   o_busy        : state is FETCH or RUN
//   o_cycle_count : saturating count of cycles spent in RUN
module instruction_fetch #(
    parameter int NBITS_PC     = fetch_pkg::NBITS_PC,
    parameter int NBITS_INSTR  = fetch_pkg::NBITS_INSTR,
    parameter int NBITS_OPCODE = fetch_pkg::NBITS_OPCODE,
    parameter int NBITS_CNT    = fetch_pkg::NBITS_CNT
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_start,
    input  logic                    i_stall,
    input  logic                    i_load_en,
    input  logic [NBITS_PC-1:0]     i_load_addr,
    input  logic [NBITS_INSTR-1:0]  i_load_data,
    input  logic [NBITS_PC-1:0]     i_pc,
    output logic                    o_wr_pc,
    output logic [NBITS_INSTR-1:0]  o_instruction,
    output logic [NBITS_OPCODE-1:0] o_opcode,
    output logic [NBITS_PC-1:0]     o_operand,
    output logic                    o_valid,
    output logic                    o_halt,
    output logic                    o_busy,
    output logic [NBITS_CNT-1:0]    o_cycle_count
);

    import fetch_pkg::*;

    fetch_state_t            state_reg;
    logic [NBITS_CNT-1:0]    cycle_count_reg;
    logic [NBITS_INSTR-1:0]  rd_data;
    logic [NBITS_OPCODE-1:0] opcode;
    logic                    is_halt_word;
    logic                    advance;
    logic                    valid;
    logic                    busy;
    logic                    load_allowed;

    assign opcode       = rd_data[NBITS_INSTR-1 -: NBITS_OPCODE];
    assign is_halt_word = (opcode == NBITS_OPCODE'(OP_HLT));

    // Loads are only honoured while nothing is being read, so the write
    // port and the read port never touch the array in the same cycle.
    assign load_allowed = (state_reg == IDLE) || (state_reg == HALT);

    // 'advance' is both the PC write enable and the memory read enable:
    // the read register always holds the word at PC-1, so both must move
    // together to keep the stream in order with nothing skipped.
    always_comb begin
        advance = 1'b0;
        valid   = 1'b0;
        busy    = 1'b0;
        case (state_reg)
            FETCH: begin
                advance = !i_stall;
                busy    = 1'b1;
            end
            RUN: begin
                advance = !i_stall && !is_halt_word;
                valid   = 1'b1;
                busy    = 1'b1;
            end
            default: begin
                advance = 1'b0;
            end
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_reg       <= IDLE;
            cycle_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        state_reg <= FETCH;
                    end
                end
                FETCH: begin
                    if (!i_stall) begin
                        state_reg <= RUN;
                    end
                end
                RUN: begin
                    // A stalled HLT stays on display until it is accepted.
                    if (!i_stall && is_halt_word) begin
                        state_reg <= HALT;
                    end
                end
                default: begin
                    state_reg <= HALT;
                end
            endcase

            if ((state_reg == RUN) && (cycle_count_reg != '1)) begin
                cycle_count_reg <= cycle_count_reg + NBITS_CNT'(1);
            end
        end
    end

    program_memory #(
        .ADDR_W (NBITS_PC),
        .DATA_W (NBITS_INSTR)
    ) u_program_memory (
        .i_clock   (i_clock),
        .i_reset   (i_reset),
        .i_wr_en   (i_load_en && load_allowed),
        .i_wr_addr (i_load_addr),
        .i_wr_data (i_load_data),
        .i_rd_en   (advance),
        .i_rd_addr (i_pc),
        .o_rd_data (rd_data)
    );

    assign o_wr_pc       = advance;
    assign o_valid       = valid;
    assign o_busy        = busy;
    assign o_halt        = (state_reg == HALT);
    assign o_instruction = rd_data;
    assign o_opcode      = opcode;
    assign o_operand     = rd_data[NBITS_PC-1:0];
    assign o_cycle_count = cycle_count_reg;

endmodule
